// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one 1R1W synchronous RAM between N requesters with round-robin read/write arbitration
//   clk, rst_n                  clock, asynchronous active-low reset
//   req_valid/we/addr/wdata     per-requester request (addr at [i*AW +: AW], wdata at [i*DW +: DW])
//   req_ready                   one-hot per class: granted requester(s) this cycle
//   rsp_valid, rsp_data         one-hot read response, one cycle after the read grant
//   ram_r_en/addr, ram_r_data   RAM read port (registered data, 1-cycle latency)
//   ram_w_en/addr/data          RAM write port
module ram_port_arbiter #(
  parameter int N  = 4,
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req_valid,
  input  logic [N-1:0]    req_we,
  input  logic [N*AW-1:0] req_addr,
  input  logic [N*DW-1:0] req_wdata,
  output logic [N-1:0]    req_ready,
  output logic [N-1:0]    rsp_valid,
  output logic [DW-1:0]   rsp_data,
  output logic            ram_r_en,
  output logic [AW-1:0]   ram_r_addr,
  input  logic [DW-1:0]   ram_r_data,
  output logic            ram_w_en,
  output logic [AW-1:0]   ram_w_addr,
  output logic [DW-1:0]   ram_w_data
);
  localparam int PW = $clog2(N);
  logic [PW-1:0] rd_ptr, wr_ptr, rd_g, wr_g, ri, wi;
  logic [N-1:0]  rd_cand, wr_cand, rd_oh, wr_oh, rsp_id;
  logic          rd_any, wr_any, same_addr, byp_hit;
  logic [DW-1:0] byp_data;
  // Gating candidates with rst_n keeps ready and RAM enables low throughout reset.
  assign rd_cand = {N{rst_n}} & req_valid & ~req_we;
  assign wr_cand = {N{rst_n}} & req_valid & req_we;
  // Scan from ptr+N-1 down to ptr so the candidate closest to ptr is the last one kept.
  always_comb begin
    rd_any = 1'b0;
    wr_any = 1'b0;
    rd_g = '0;
    wr_g = '0;
    ri = '0;
    wi = '0;
    for (int k = N - 1; k >= 0; k--) begin
      ri = PW'((int'(rd_ptr) + k) % N);
      wi = PW'((int'(wr_ptr) + k) % N);
      rd_g = rd_cand[ri] ? ri : rd_g;
      wr_g = wr_cand[wi] ? wi : wr_g;
      rd_any = rd_any | rd_cand[ri];
      wr_any = wr_any | wr_cand[wi];
    end
  end
  assign rd_oh      = rd_any ? (N'(1) << rd_g) : '0;
  assign wr_oh      = wr_any ? (N'(1) << wr_g) : '0;
  assign req_ready  = rd_oh | wr_oh;
  assign ram_r_en   = rd_any;
  assign ram_r_addr = req_addr[rd_g*AW +: AW];
  assign ram_w_en   = wr_any;
  assign ram_w_addr = req_addr[wr_g*AW +: AW];
  assign ram_w_data = req_wdata[wr_g*DW +: DW];
  assign same_addr  = rd_any & wr_any & (ram_r_addr == ram_w_addr);
  assign rsp_valid  = rsp_id;
  // The RAM returns pre-write data on a same-address collision, so substitute the captured write.
  assign rsp_data   = byp_hit ? byp_data : ram_r_data;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      rsp_id   <= '0;
      byp_hit  <= 1'b0;
      byp_data <= '0;
    end else begin
      if (rd_any) rd_ptr <= (rd_g == PW'(N - 1)) ? '0 : rd_g + 1'b1;
      if (wr_any) wr_ptr <= (wr_g == PW'(N - 1)) ? '0 : wr_g + 1'b1;
      rsp_id  <= rd_oh;
      byp_hit <= same_addr;
      if (same_addr) byp_data <= ram_w_data;
    end
  end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: scoreboard bench for ram_port_arbiter with a behavioural 1R1W RAM
module tb_ram_port_arbiter;
  typedef struct {int id; logic [31:0] data;} rsp_t;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   req_valid = '0, req_we = '0, req_ready, rsp_valid;
  logic [31:0]  req_addr = '0;
  logic [127:0] req_wdata = '0;
  logic [31:0]  rsp_data, ram_r_data, ram_w_data;
  logic         ram_r_en, ram_w_en;
  logic [7:0]   ram_r_addr, ram_w_addr;
  logic [31:0]  mem [256];
  logic [31:0]  shadow [256];
  rsp_t         q[$];
  int           rd_m, wr_m, n_checks, n_pass;
  ram_port_arbiter #(.N(4), .AW(8), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .ram_r_en(ram_r_en),
    .ram_r_addr(ram_r_addr), .ram_r_data(ram_r_data), .ram_w_en(ram_w_en),
    .ram_w_addr(ram_w_addr), .ram_w_data(ram_w_data)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (ram_w_en) mem[ram_w_addr] <= ram_w_data;
    if (ram_r_en) ram_r_data <= mem[ram_r_addr];
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  function automatic int rr(input logic [3:0] cand, input int ptr);
    for (int k = 0; k < 4; k++) begin
      int j = (ptr + k) % 4;
      if (cand[j[1:0]]) return j;
    end
    return -1;
  endfunction
  task automatic set_req(input int i, input logic we, input logic [7:0] a, input logic [31:0] d);
    req_valid[i] = 1'b1;
    req_we[i] = we;
    req_addr[i*8 +: 8] = a;
    req_wdata[i*32 +: 32] = d;
  endtask
  task automatic clear_req();
    req_valid = '0;
    req_we = '0;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check_cycle();
    int gr, gw;
    logic [3:0] exp_ready;
    logic [31:0] d;
    rsp_t e;
    @(negedge clk);
    gr = rr(req_valid & ~req_we, rd_m);
    gw = rr(req_valid & req_we, wr_m);
    exp_ready = '0;
    if (gr >= 0) exp_ready[gr] = 1'b1;
    if (gw >= 0) exp_ready[gw] = 1'b1;
    check("ready", req_ready, exp_ready);
    check("r_en", ram_r_en, gr >= 0);
    check("w_en", ram_w_en, gw >= 0);
    if (gr >= 0) check("r_addr", ram_r_addr, req_addr[gr*8 +: 8]);
    if (gw >= 0) check("w_addr", ram_w_addr, req_addr[gw*8 +: 8]);
    if (gw >= 0) check("w_data", ram_w_data, req_wdata[gw*32 +: 32]);
    if (q.size() > 0) begin
      e = q.pop_front();
      check("rsp_valid", rsp_valid, 4'b1 << e.id);
      check("rsp_data", rsp_data, e.data);
    end else check("rsp_idle", rsp_valid, 4'b0);
    if (gr >= 0) begin
      d = (gw >= 0 && req_addr[gw*8 +: 8] == req_addr[gr*8 +: 8]) ? req_wdata[gw*32 +: 32]
                                                                 : shadow[req_addr[gr*8 +: 8]];
      q.push_back('{gr, d});
      rd_m = (gr + 1) % 4;
    end
    if (gw >= 0) begin
      shadow[req_addr[gw*8 +: 8]] = req_wdata[gw*32 +: 32];
      wr_m = (gw + 1) % 4;
    end
  endtask
  task automatic step();
    check_cycle();
    tick();
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_ready", req_ready, 4'b0);
    check("rst_r_en", ram_r_en, 1'b0);
    check("rst_w_en", ram_w_en, 1'b0);
    check("rst_rsp", rsp_valid, 4'b0);
    rd_m = 0;
    wr_m = 0;
    q.delete();
    repeat (2) tick();
    check("rst_rsp_hold", rsp_valid, 4'b0);
    rst_n = 1'b1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    bit hit;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 32'(i);
      shadow[i] = 32'(i);
    end
    tick();
    do_reset();
    set_req(0, 1'b0, 8'h05, 32'h0);
    step();
    clear_req();
    step();
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 8'(i * 3 + 1), 32'h0);
    repeat (9) step();
    clear_req();
    step();
    set_req(1, 1'b1, 8'h10, 32'hDEADBEEF);
    set_req(2, 1'b0, 8'h10, 32'h0);
    step();
    clear_req();
    set_req(0, 1'b0, 8'h10, 32'h0);
    step();
    clear_req();
    step();
    set_req(0, 1'b1, 8'h20, 32'h12345678);
    set_req(3, 1'b0, 8'h30, 32'h0);
    step();
    clear_req();
    step();
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 8'(i + 8'h40), 32'h0);
    hit = 1'b0;
    for (int c = 0; c < 4 && !hit; c++) begin
      check_cycle();
      hit = req_ready[2];
      tick();
    end
    check("no_starve", hit, 1'b1);
    clear_req();
    step();
    for (int c = 0; c < 40; c++) begin
      clear_req();
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 1) == 1)
          set_req(i, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), $urandom);
      step();
    end
    clear_req();
    step();
    set_req(0, 1'b0, 8'h05, 32'h0);
    check_cycle();
    do_reset();
    clear_req();
    step();
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 8'(i + 2), 32'h0);
    step();
    clear_req();
    step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
